// File: rtl/digit_neg_accum.sv
// Accumulates a frame of NUM_DIGITS signed 4-bit negated BCD digits into an 8-bit sum.
// Optional macro DIGIT_ERR_ABORT_EN: an error digit ends the frame early instead of being skipped.
module digit_neg_accum #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] neg_digit,
    input  logic       digit_err,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       err_out,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(NUM_DIGITS);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] result_nx;
    logic       err_nx;
    logic       beat;
    logic [3:0] cnt_inc;
    logic [7:0] digit_ext;

    // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
    // upstream holds neg_digit/digit_err stable while in_valid is high and not accepted.
    assign beat      = in_valid && in_ready;
    assign cnt_inc   = cnt + 4'd1;
    assign digit_ext = {{4{neg_digit[3]}}, neg_digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            result  <= 8'd0;
            err_out <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            result  <= result_nx;
            err_out <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        result_nx = result;
        err_nx    = err_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = ACCUM;
                    cnt_nx    = 4'd0;
                    result_nx = 8'd0;
                    err_nx    = 1'b0;
                end
            end
            ACCUM: begin
                if (beat) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == LAST_COUNT) begin
                        state_nx = DONE;
                    end
                    // Error digits never contribute to the sum; the flag stays set until next start.
                    if (digit_err) begin
                        err_nx = 1'b1;
`ifdef DIGIT_ERR_ABORT_EN
                        state_nx = DONE;
`endif
                    end else begin
                        result_nx = result + digit_ext;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign in_ready     = (state == ACCUM);
    assign result_valid = (state == DONE);
    assign busy         = (state == ACCUM) || (state == DONE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_digit_neg_accum.sv
// Bench for digit_neg_accum: three instances (4, 3 and 15 digits) driven from a vector table.
module tb_digit_neg_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_bus = 3'b000;
    logic       in_valid = 1'b0;
    logic [3:0] neg_digit = 4'd0;
    logic       digit_err = 1'b0;

    logic [2:0] ready_w, valid_w, err_w, busy_w;
    logic [7:0] result_w [3];
    logic [1:0] state_w [3];

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    digit_neg_accum #(.NUM_DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_bus[0]), .in_valid(in_valid), .in_ready(ready_w[0]),
        .neg_digit(neg_digit), .digit_err(digit_err), .result(result_w[0]),
        .result_valid(valid_w[0]), .err_out(err_w[0]), .busy(busy_w[0]), .state_dbg(state_w[0]));

    digit_neg_accum #(.NUM_DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_bus[1]), .in_valid(in_valid), .in_ready(ready_w[1]),
        .neg_digit(neg_digit), .digit_err(digit_err), .result(result_w[1]),
        .result_valid(valid_w[1]), .err_out(err_w[1]), .busy(busy_w[1]), .state_dbg(state_w[1]));

    digit_neg_accum #(.NUM_DIGITS(15)) dut15 (
        .clk(clk), .rst(rst), .start(start_bus[2]), .in_valid(in_valid), .in_ready(ready_w[2]),
        .neg_digit(neg_digit), .digit_err(digit_err), .result(result_w[2]),
        .result_valid(valid_w[2]), .err_out(err_w[2]), .busy(busy_w[2]), .state_dbg(state_w[2]));

    logic       s_ready, s_valid, s_err, s_busy;
    logic [7:0] s_result;

    always_comb begin
        s_ready  = ready_w[cur];
        s_valid  = valid_w[cur];
        s_err    = err_w[cur];
        s_busy   = busy_w[cur];
        s_result = result_w[cur];
    end

    typedef struct {
        int          sel;
        logic [3:0]  n_beats;
        logic [59:0] digits;
        logic [14:0] errs;
        logic [7:0]  gaps;
        logic        rnd_gaps;
        logic        poke_start;
        logic [7:0]  exp_result;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t       v;
        logic [8:0] exp;
        int         gap;
        v = vecs[k];
        cur = v.sel;
        exp_q.push_back({v.exp_err, v.exp_result});

        @(negedge clk);
        start_bus[v.sel] = 1'b1;
        @(posedge clk); #1;
        check($sformatf("v%0d start_clear_result", k), {24'd0, s_result}, 32'd0);
        check($sformatf("v%0d start_clear_err", k), {31'd0, s_err}, 32'd0);
        check($sformatf("v%0d ready_in_accum", k), {31'd0, s_ready}, 32'd1);
        check($sformatf("v%0d busy_in_accum", k), {31'd0, s_busy}, 32'd1);

        for (int i = 0; i < int'(v.n_beats); i++) begin
            gap = (i < 4) ? int'(v.gaps[i*2 +: 2]) : 0;
            if (v.rnd_gaps) gap += $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                start_bus[v.sel] = v.poke_start;
                @(posedge clk); #1;
                check($sformatf("v%0d no_early_pulse", k), {31'd0, s_valid}, 32'd0);
                check($sformatf("v%0d wait_ready", k), {31'd0, s_ready}, 32'd1);
            end
            @(negedge clk);
            start_bus[v.sel] = 1'b0;
            in_valid  = 1'b1;
            neg_digit = v.digits[i*4 +: 4];
            digit_err = v.errs[i];
            @(posedge clk); #1;
            if (i == int'(v.n_beats) - 1) begin
                check($sformatf("v%0d pulse_latency", k), {31'd0, s_valid}, 32'd1);
                exp = exp_q.pop_front();
                check($sformatf("v%0d result", k), {24'd0, s_result}, {24'd0, exp[7:0]});
                check($sformatf("v%0d err_out", k), {31'd0, s_err}, {31'd0, exp[8]});
            end else begin
                check($sformatf("v%0d no_pulse_mid", k), {31'd0, s_valid}, 32'd0);
            end
        end

        @(negedge clk);
        in_valid  = 1'b0;
        digit_err = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d pulse_width", k), {31'd0, s_valid}, 32'd0);
        check($sformatf("v%0d idle_not_busy", k), {31'd0, s_busy}, 32'd0);
        check($sformatf("v%0d result_hold", k), {24'd0, s_result}, {24'd0, v.exp_result});
        check($sformatf("v%0d err_hold", k), {31'd0, s_err}, {31'd0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 4'd4, 60'hCDEF, 15'd0, 8'h00, 1'b0, 1'b0, 8'hF6, 1'b0};
        vecs[1] = '{0, 4'd4, 60'h8888, 15'd0, 8'h00, 1'b0, 1'b0, 8'hE0, 1'b0};
        vecs[2] = '{0, 4'd4, 60'h0000, 15'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{0, 4'd4, 60'h17FF, 15'd0, 8'h48, 1'b0, 1'b1, 8'h06, 1'b0};
`ifdef DIGIT_ERR_ABORT_EN
        vecs[4] = '{1, 4'd2, 60'hF7F, 15'b010, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1};
        vecs[6] = '{1, 4'd1, 60'h115, 15'b001, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
`else
        vecs[4] = '{1, 4'd3, 60'hF7F, 15'b010, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b1};
        vecs[6] = '{1, 4'd3, 60'h115, 15'b001, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1};
`endif
        vecs[5] = '{2, 4'd15, {15{4'h8}}, 15'd0, 8'h00, 1'b0, 1'b0, 8'h88, 1'b0};
        vecs[7] = '{0, 4'd4, 60'h9999, 15'd0, 8'h00, 1'b1, 1'b1, 8'hE4, 1'b0};

        // Reset state on all three instances
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_result%0d", d), {24'd0, result_w[d]}, 32'd0);
            check($sformatf("reset_flags%0d", d),
                  {28'd0, ready_w[d], valid_w[d], err_w[d], busy_w[d]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(k);

        // Mid-frame reset: two beats accepted, then asynchronous reset between edges
        cur = 0;
        @(negedge clk);
        start_bus[0] = 1'b1;
        @(negedge clk);
        start_bus[0] = 1'b0;
        in_valid = 1'b1;
        neg_digit = 4'h1;
        @(negedge clk);
        neg_digit = 4'h2;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_partial_sum", {24'd0, s_result}, 32'h03);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_result", {24'd0, s_result}, 32'd0);
        check("midrst_async_flags", {28'd0, s_ready, s_valid, s_err, s_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("midrst_no_pulse", {31'd0, s_valid}, 32'd0);
            check("midrst_waits_idle", {31'd0, s_busy}, 32'd0);
        end

        run_vec(0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
